m3_sopc_pio_key: RTL and testbench

Avalon-MM slave input PIO for the m3_sopc system, the read-side counterpart of the LED output PIO. It samples an external WIDTH-bit input bus such as push-buttons or DIP switches. Each bit passes through a two-flop synchronizer and a per-bit debounce counter. The CPU can read the debounced level, an edge-capture register and an interrupt mask, and the block drives a level-sensitive IRQ to the SCR1 interrupt controller.

---
 rtl/m3_pio_pkg.sv | 24 ++
 rtl/m3_pio_debounce.sv | 70 +++++++
 rtl/m3_sopc_pio_key.sv | 98 +++++++++
 tb/tb_m3_sopc_pio_key.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/m3_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m3_pio_pkg
//  Description : Shared register-map and edge-select constants for the input PIO.
//  Revision    : 1.0 - initial release
// ============================================================================
package m3_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Counter width for a debounce length; a zero-width vector is never produced.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m3_pio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : m3_pio_debounce
//  Description : One input bit: two-flop synchronizer plus restartable debounce counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module m3_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);
    import m3_pio_pkg::*;

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic sync0_q;
    logic sync1_q;
    logic stable_q;
    logic stable_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync0_q  <= din;
            sync1_q  <= sync0_q;
            stable_q <= stable_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_passthru
            always_comb stable_d = sync1_q;
        end else begin : g_count
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Any return to agreement restarts the count, filtering short glitches.
            always_comb begin
                stable_d = stable_q;
                cnt_d    = cnt_q + CNT_W'(1);
                if (sync1_q == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = sync1_q;
                    cnt_d    = '0;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/m3_sopc_pio_key.sv
`default_nettype none
// ============================================================================
//  Module      : m3_sopc_pio_key
//  Description : Avalon-MM input PIO with debounce, edge capture, IRQ mask and level IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module m3_sopc_pio_key #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    import m3_pio_pkg::*;

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic             wr;
    logic             unused_writedata;

    assign unused_writedata = &{1'b0, writedata};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            m3_pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (in_port[i]),
                .stable  (stable[i])
            );
        end
    endgenerate

    always_comb begin
        wr        = chipselect & ~write_n;
        rise      = stable & ~stable_dly_q;
        fall      = ~stable & stable_dly_q;
        irqmask_d = irqmask_q;
        clr       = '0;
        case (EDGE_TYPE)
            EDGE_RISE: evt = rise;
            EDGE_FALL: evt = fall;
            default:   evt = rise | fall;
        endcase
        if (wr && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr && (address == ADDR_EDGECAP)) begin
            clr = writedata[WIDTH-1:0];
        end
        // OR-ing the event last lets a new edge win over a same-cycle clear.
        edgecap_d = (edgecap_q & ~clr) | evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_dly_q <= '0;
            irqmask_q    <= '0;
            edgecap_q    <= '0;
        end else begin
            stable_dly_q <= stable;
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(stable);
            ADDR_IRQMASK: readdata = 32'(irqmask_q);
            ADDR_EDGECAP: readdata = 32'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_m3_sopc_pio_key.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m3_sopc_pio_key
//  Description : Scoreboard bench for two PIO instances (any-edge and rising-edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m3_sopc_pio_key;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata2, readdata0;
    logic        irq2, irq0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m3_sopc_pio_key #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata2), .irq(irq2));

    m3_sopc_pio_key #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata0), .irq(irq0));

    // Reference model: a bit's level flips once the last D synchronized samples
    // all disagree with it; samp[j] holds in_port as sampled j+1 edges ago.
    logic [7:0] samp [0:D];
    logic [7:0] m_stable, m_prev, m_cap2, m_cap0, m_mask, flip, m_clr;

    always_comb begin
        flip = '1;
        for (int b = 0; b < 8; b++)
            for (int j = 1; j <= D; j++)
                if (samp[j][b] == m_stable[b]) flip[b] = 1'b0;
        m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j <= D; j++) samp[j] <= 8'h00;
            m_stable <= 8'h00;
            m_prev   <= 8'h00;
            m_cap2   <= 8'h00;
            m_cap0   <= 8'h00;
            m_mask   <= 8'h00;
        end else begin
            samp[0] <= in_port;
            for (int j = 1; j <= D; j++) samp[j] <= samp[j-1];
            m_stable <= m_stable ^ flip;
            m_prev   <= m_stable;
            m_cap2   <= (m_cap2 & ~m_clr) | (m_stable ^ m_prev);
            m_cap0   <= (m_cap0 & ~m_clr) | (m_stable & ~m_prev);
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[7:0];
        end
    end

    typedef struct {
        logic [1:0]  a;
        logic [31:0] rd2;
        logic [31:0] rd0;
        logic        i2;
        logic        i0;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus read cycle pops one expected response.
    always @(negedge clk) begin
        if (reset_n && chipselect && write_n) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read with no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("any.rd[%0d]", e.a), readdata2, e.rd2);
                chk($sformatf("rise.rd[%0d]", e.a), readdata0, e.rd0);
                chk($sformatf("any.irq@%0d", e.a), {31'd0, irq2}, {31'd0, e.i2});
                chk($sformatf("rise.irq@%0d", e.a), {31'd0, irq0}, {31'd0, e.i0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e2, input logic [31:0] e0,
                      input logic i2, input logic i0);
        exp_t e;
        e.a = a; e.rd2 = e2; e.rd0 = e0; e.i2 = i2; e.i0 = i0;
        q.push_back(e);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick();
        chipselect = 1'b0;
    endtask

    function automatic logic [31:0] mrd(input logic [1:0] a, input logic [7:0] cap);
        case (a)
            2'd0:    return {24'd0, m_stable};
            2'd2:    return {24'd0, m_mask};
            2'd3:    return {24'd0, cap};
            default: return 32'd0;
        endcase
    endfunction

    task automatic rd_model(input logic [1:0] a);
        rd(a, mrd(a, m_cap2), mrd(a, m_cap0), |(m_cap2 & m_mask), |(m_cap0 & m_mask));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Reset values
        for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, 32'd0, 1'b0, 1'b0);

        // Three-cycle glitch is rejected
        in_port = 8'h01; ticks(3);
        in_port = 8'h00; ticks(8);
        rd(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rd(2'd3, 32'd0, 32'd0, 1'b0, 1'b0);

        // Debounced press: level at k+5, capture and irq at k+6
        wr(2'd2, 32'h0000_0001);
        in_port = 8'h01;
        ticks(5);
        rd(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rd(2'd0, 32'h01, 32'h01, 1'b0, 1'b0);
        rd(2'd3, 32'h01, 32'h01, 1'b1, 1'b1);
        in_port = 8'h00; ticks(8);
        rd(2'd3, 32'h01, 32'h01, 1'b1, 1'b1);
        rd(2'd0, 32'h00, 32'h00, 1'b1, 1'b1);

        // Write-1-to-clear
        in_port = 8'h80; ticks(8);
        in_port = 8'h00; ticks(8);
        rd(2'd3, 32'h81, 32'h81, 1'b1, 1'b1);
        wr(2'd3, 32'h0000_0001);
        rd(2'd3, 32'h80, 32'h80, 1'b0, 1'b0);

        // Set beats clear: write lands on the edge that captures bit 2
        in_port = 8'h04; ticks(6);
        wr(2'd3, 32'h0000_0004);
        rd(2'd3, 32'h84, 32'h84, 1'b0, 1'b0);
        wr(2'd3, 32'h0000_0084);
        rd(2'd3, 32'h00, 32'h00, 1'b0, 1'b0);

        // Falling edge: captured only by the any-edge instance
        in_port = 8'h00; ticks(8);
        rd(2'd3, 32'h04, 32'h00, 1'b0, 1'b0);
        wr(2'd3, 32'h0000_00FF);
        rd(2'd3, 32'h00, 32'h00, 1'b0, 1'b0);

        // Reset at count 2 of a rising transition
        in_port = 8'h01; ticks(4);
        reset_n = 1'b0; in_port = 8'h00;
        ticks(2);
        reset_n = 1'b1;
        ticks(10);
        for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, 32'd0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        wr(2'd2, {24'd0, 8'($urandom)});
        hold = 0;
        for (int n = 0; n < 500; n++) begin
            if (hold == 0) begin
                in_port = 8'($urandom);
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rd_model(2'($urandom_range(0, 3)));
                5:             wr(2'd2, $urandom);
                6:             wr(2'd3, $urandom);
                7:             wr(2'($urandom_range(0, 1)), $urandom);
                default:       tick();
            endcase
        end
        for (int a = 0; a < 4; a++) rd_model(2'(a));

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected reads left unconsumed, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
